// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - ordered multi-domain reset release with per-stage ack handshake
module reset_sequencer #(
  parameter int NUM_STAGES  = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int STAGE_DELAY = 16,
  parameter int ACK_TIMEOUT = 255,
  parameter int SYNC_FF     = 2,
  parameter int CNT_W       = 8,
  localparam int STAGE_W    = (NUM_STAGES > 2) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sw_reset_req,
  input  logic [NUM_STAGES-1:0] stage_ack,
  output logic [NUM_STAGES-1:0] stage_rst_n,
  output logic                  all_ready,
  output logic                  busy,
  output logic [STAGE_W-1:0]    cur_stage,
  output logic                  seq_err
);

  localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   DELAY_LAST   = CNT_W'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [STAGE_W-1:0] LAST_STAGE   = STAGE_W'(NUM_STAGES - 1);

  typedef enum logic [2:0] {
    S_HOLD,
    S_DELAY,
    S_WAIT_ACK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      count;
  logic [NUM_STAGES-1:0] sync_q [SYNC_FF];
  logic [NUM_STAGES-1:0] sack;
  logic                  fault;

  // Each ack comes from its own clock domain, so only the last synchronizer stage is trusted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_FF; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= stage_ack;
      for (int i = 1; i < SYNC_FF; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sack = sync_q[SYNC_FF-1];

  // A valid ack masks a timeout expiring in the same cycle.
  assign fault = ((state == S_WAIT_ACK) && !sack[cur_stage] && (count == TIMEOUT_LAST)) ||
                 ((state == S_DONE) && !(&sack));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_HOLD;
      count       <= '0;
      cur_stage   <= '0;
      stage_rst_n <= '0;
      all_ready   <= 1'b0;
      busy        <= 1'b1;
      seq_err     <= 1'b0;
    end else if (sw_reset_req) begin
      state       <= S_HOLD;
      count       <= '0;
      cur_stage   <= '0;
      stage_rst_n <= '0;
      all_ready   <= 1'b0;
      busy        <= 1'b1;
      seq_err     <= 1'b0;
    end else if (fault) begin
      state       <= S_ERROR;
      count       <= '0;
      stage_rst_n <= '0;
      all_ready   <= 1'b0;
      busy        <= 1'b0;
      seq_err     <= 1'b1;
    end else begin
      if (busy) count <= count + CNT_W'(1);
      case (state)
        S_HOLD: begin
          if (count == HOLD_LAST) begin
            state     <= S_DELAY;
            count     <= '0;
            cur_stage <= '0;
          end
        end
        S_DELAY: begin
          if (count == DELAY_LAST) begin
            stage_rst_n[cur_stage] <= 1'b1;
            state                  <= S_WAIT_ACK;
            count                  <= '0;
          end
        end
        S_WAIT_ACK: begin
          if (sack[cur_stage]) begin
            count <= '0;
            if (cur_stage == LAST_STAGE) begin
              state     <= S_DONE;
              all_ready <= 1'b1;
              busy      <= 1'b0;
            end else begin
              cur_stage <= cur_stage + STAGE_W'(1);
              state     <= S_DELAY;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - scoreboard bench for reset_sequencer against an edge-timeline model
module tb_reset_sequencer;

  localparam int N     = 4;
  localparam int HOLD  = 8;
  localparam int DLY   = 16;
  localparam int TMO   = 255;
  localparam int SFF   = 2;
  localparam int NEVER = 1000000;

  typedef struct packed {
    logic [N-1:0] rst_n;
    logic         all_ready;
    logic         busy;
    logic [1:0]   cur;
    logic         seq_err;
  } snap_t;

  typedef struct packed {
    int    at;
    snap_t s;
  } exp_t;

  localparam snap_t RST_SNAP = '{rst_n: '0, all_ready: 1'b0, busy: 1'b1, cur: 2'd0, seq_err: 1'b0};

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         sw_reset_req = 1'b0;
  logic [N-1:0] stage_ack;
  logic [N-1:0] stage_rst_n;
  logic         all_ready;
  logic         busy;
  logic [1:0]   cur_stage;
  logic         seq_err;

  logic [N-1:0] ack_base = '0;
  logic [N-1:0] drop_mask = '0;
  int           ack_delay [N] = '{default: 0};
  int           hi_cnt [N] = '{default: 0};

  int    edge_no = 0;
  int    checks = 0;
  int    errors = 0;
  exp_t  exp_q[$];
  snap_t prev_obs = RST_SNAP;
  snap_t last_exp = RST_SNAP;
  snap_t model_snap = RST_SNAP;
  int    plan_end;
  bit    plan_done;

  reset_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .sw_reset_req (sw_reset_req),
    .stage_ack    (stage_ack),
    .stage_rst_n  (stage_rst_n),
    .all_ready    (all_ready),
    .busy         (busy),
    .cur_stage    (cur_stage),
    .seq_err      (seq_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_no <= edge_no + 1;

  // Stage model: ack follows its own reset release after ack_delay cycles, drop_mask forces a glitch.
  assign stage_ack = ack_base & ~drop_mask;
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (stage_rst_n[i]) hi_cnt[i] = hi_cnt[i] + 1;
      else hi_cnt[i] = 0;
      ack_base[i] = stage_rst_n[i] && (hi_cnt[i] > ack_delay[i]);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_no, act, exp);
    end
  endtask

  always @(negedge clk) begin
    snap_t cur;
    exp_t  e;
    cur = {stage_rst_n, all_ready, busy, cur_stage, seq_err};
    if (cur != prev_obs) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_change at edge %0d: got %0h, no change expected", edge_no, cur);
      end else begin
        e = exp_q.pop_front();
        last_exp = e.s;
        check("event_edge", e.at == edge_no ? e.at : edge_no, e.at);
        check("event_value", 32'(cur), 32'(e.s));
      end
      prev_obs = cur;
    end
  end

  function automatic void expect_at(input int at, input snap_t s);
    exp_t e;
    if (s != model_snap) begin
      e.at = at;
      e.s  = s;
      exp_q.push_back(e);
      model_snap = s;
    end
  endfunction

  function automatic void cancel_after(input int at);
    while (exp_q.size() > 0 && exp_q[exp_q.size()-1].at > at) exp_q.delete(exp_q.size()-1);
    model_snap = (exp_q.size() > 0) ? exp_q[exp_q.size()-1].s : last_exp;
  endfunction

  // Timeline of visible output changes for a sequence whose HOLD starts at edge 'start'.
  task automatic plan(input int start);
    snap_t s;
    int t, rel, w;
    s = RST_SNAP;
    expect_at(start, s);
    t = start + HOLD;
    plan_done = 1'b0;
    for (int i = 0; i < N; i++) begin
      rel = t + DLY;
      s.rst_n[i] = 1'b1;
      expect_at(rel, s);
      w = ack_delay[i] + SFF + 1;
      if (w > TMO) begin
        s.rst_n = '0; s.all_ready = 1'b0; s.busy = 1'b0; s.seq_err = 1'b1;
        plan_end = rel + TMO;
        expect_at(plan_end, s);
        return;
      end
      t = rel + w;
      if (i == N - 1) begin
        s.all_ready = 1'b1;
        s.busy = 1'b0;
      end else begin
        s.cur = 2'(i + 1);
      end
      expect_at(t, s);
    end
    plan_end = t;
    plan_done = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic goto_edge(input int n);
    while (edge_no < n) step();
  endtask

  task automatic drain(input int budget);
    int lim;
    lim = edge_no + budget;
    while (exp_q.size() > 0 && edge_no < lim) step();
    check("drain_pending", exp_q.size(), 0);
    if (exp_q.size() > 0) begin
      exp_q.delete();
      model_snap = last_exp;
    end
    repeat (3) step();
  endtask

  task automatic sw_restart();
    int s_at;
    s_at = edge_no + 1;
    cancel_after(edge_no);
    plan(s_at);
    sw_reset_req = 1'b1;
    step();
    sw_reset_req = 1'b0;
  endtask

  task automatic async_reset_pulse();
    #5;
    reset = 1'b0;
    #1;
    check("async_rst_n", 32'(stage_rst_n), 0);
    check("async_busy", 32'(busy), 1);
    check("async_ready", 32'(all_ready), 0);
    check("async_err", 32'(seq_err), 0);
    cancel_after(edge_no);
    expect_at(edge_no + 1, RST_SNAP);
    repeat (3) step();
    reset = 1'b1;
    plan(edge_no);
  endtask

  task automatic glitch(input int k);
    snap_t s;
    s = model_snap;
    s.rst_n = '0; s.all_ready = 1'b0; s.busy = 1'b0; s.seq_err = 1'b1;
    cancel_after(edge_no);
    expect_at(edge_no + SFF + 1, s);
    drop_mask[k] = 1'b1;
    step();
    drop_mask[k] = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, s0, x, kind, r;
    step();
    step();
    check("reset_rst_n", 32'(stage_rst_n), 0);
    check("reset_ready", 32'(all_ready), 0);
    check("reset_busy", 32'(busy), 1);
    check("reset_cur", 32'(cur_stage), 0);
    check("reset_err", 32'(seq_err), 0);

    reset = 1'b1;
    base = edge_no;
    plan(base);
    goto_edge(base + 23);
    check("rel0_before", 32'(stage_rst_n), 0);
    step();
    check("rel0_at24", 32'(stage_rst_n), 1);
    goto_edge(base + 83);
    check("ready_before84", 32'(all_ready), 0);
    step();
    check("ready_at84", 32'(all_ready), 1);
    check("busy_at84", 32'(busy), 0);
    drain(100);

    ack_delay[2] = NEVER;
    sw_restart();
    s0 = edge_no;
    goto_edge(s0 + 316);
    check("tmo_before", 32'(seq_err), 0);
    step();
    check("tmo_err", 32'(seq_err), 1);
    check("tmo_rst_n", 32'(stage_rst_n), 0);
    repeat (1000) step();
    check("err_stays", {28'd0, stage_rst_n, all_ready, seq_err}, 32'h1);
    drain(10);

    ack_delay[2] = 0;
    sw_restart();
    s0 = edge_no;
    check("sw_clears_err", 32'(seq_err), 0);
    goto_edge(s0 + 84);
    check("sw_ready_84", 32'(all_ready), 1);
    drain(100);

    x = edge_no;
    glitch(1);
    goto_edge(x + 2);
    check("loss_before", 32'(seq_err), 0);
    step();
    check("loss_err", 32'(seq_err), 1);
    check("loss_rst_n", 32'(stage_rst_n), 0);
    drain(20);

    sw_restart();
    s0 = edge_no;
    goto_edge(s0 + 45);
    sw_restart();
    check("sw_vs_ack_cur", 32'(cur_stage), 0);
    check("sw_vs_ack_rst", 32'(stage_rst_n), 0);
    drain(200);

    sw_restart();
    s0 = edge_no;
    goto_edge(s0 + 25);
    async_reset_pulse();
    drain(200);

    ack_delay[1] = TMO - SFF - 1;
    sw_restart();
    drain(2000);
    ack_delay[1] = TMO - SFF;
    sw_restart();
    drain(2000);
    ack_delay[1] = 0;

    for (int it = 0; it < 12; it++) begin
      for (int i = 0; i < N; i++) begin
        r = int'($urandom_range(0, 9));
        if (r < 6) ack_delay[i] = int'($urandom_range(0, 6));
        else if (r < 8) ack_delay[i] = int'($urandom_range(TMO - SFF - 3, TMO - SFF));
        else if (r == 8) ack_delay[i] = int'($urandom_range(20, 120));
        else ack_delay[i] = NEVER;
      end
      sw_restart();
      s0 = edge_no;
      kind = int'($urandom_range(0, 3));
      if (kind == 3 && plan_done) begin
        goto_edge(plan_end + int'($urandom_range(0, 10)));
        glitch(int'($urandom_range(0, N - 1)));
      end else if (kind == 1 || kind == 2) begin
        goto_edge(s0 + int'($urandom_range(0, plan_end - s0)));
        if (kind == 1) sw_restart();
        else async_reset_pulse();
      end
      drain(3000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
